// File: rtl/serial_subtractor_4.sv
// Bit-serial ripple-borrow subtractor: {Bout,Diff} = X - Y - Bin, LSB first.
// One full-subtractor cell, shift registers and a start/done handshake.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, accepted only while ready=1
//   X      in   WIDTH  minuend, sampled on the accepting edge
//   Y      in   WIDTH  subtrahend, sampled on the accepting edge
//   Bin    in   1      borrow-in, sampled on the accepting edge
//   ready  out  1      idle, able to accept
//   busy   out  1      shifting bits
//   done   out  1      one-cycle pulse, results just updated
//   Diff   out  WIDTH  difference mod 2^WIDTH
//   Bout   out  1      borrow-out (X < Y+Bin, unsigned)
//   Ovf    out  1      two's-complement overflow

module serial_subtractor_4 #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] xs;
   logic [WIDTH-1:0] ys;
   logic [WIDTH-1:0] rs;
   logic             b;
   logic [CW-1:0]    cnt;
   logic             xm;
   logic             ym;

   logic             xb;
   logic             yb;
   logic             d;
   logic             bn;
   logic             last;
   logic [WIDTH-1:0] rs_nxt;

   // Full-subtractor cell on the current operand LSBs.
   always_comb begin
      xb     = xs[0];
      yb     = ys[0];
      d      = xb ^ yb ^ b;
      bn     = (~xb & yb) | (~xb & b) | (yb & b);
      rs_nxt = {d, rs[WIDTH-1:1]};
      last   = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath. Results are written only on the final step so partial
   // differences never reach the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         xs   <= '0;
         ys   <= '0;
         rs   <= '0;
         b    <= 1'b0;
         cnt  <= '0;
         xm   <= 1'b0;
         ym   <= 1'b0;
         Diff <= '0;
         Bout <= 1'b0;
         Ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  xs  <= X;
                  ys  <= Y;
                  rs  <= '0;
                  b   <= Bin;
                  cnt <= '0;
                  xm  <= X[WIDTH-1];
                  ym  <= Y[WIDTH-1];
               end
            end
            BUSY: begin
               xs  <= xs >> 1;
               ys  <= ys >> 1;
               rs  <= rs_nxt;
               b   <= bn;
               cnt <= cnt + CW'(1);
               if (last) begin
                  Diff <= rs_nxt;
                  Bout <= bn;
                  // Overflow only possible when operand signs differ and
                  // the result sign departs from the minuend sign.
                  Ovf  <= (xm != ym) & (rs_nxt[WIDTH-1] != xm);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_4.sv
// Scoreboard bench for serial_subtractor_4 (WIDTH=4).
// Expected results come from integer arithmetic on the accepted operands.

module tb_serial_subtractor_4;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] X;
   logic [W-1:0] Y;
   logic         Bin;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;
   logic         Ovf;

   serial_subtractor_4 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .X     (X),
      .Y     (Y),
      .Bin   (Bin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout),
      .Ovf   (Ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   acc_log[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   bit   rst_edge = 1'b1;

   logic [W-1:0] last_d = '0;
   logic         last_bo = 1'b0;
   logic         last_ov = 1'b0;
   logic         prev_done = 1'b0;

   function automatic exp_t model(input int x, input int y, input int bi, input int c);
      exp_t e;
      int r;
      int sx;
      int sy;
      int s;
      r    = x - y - bi;
      e.d  = W'(r & ((1 << W) - 1));
      e.bo = (r < 0);
      sx   = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
      sy   = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
      s    = sx - sy - bi;
      e.ov = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
      e.cyc = c;
      return e;
   endfunction

   // Acceptance tracker: pushes the expected result when an op is taken.
   always @(posedge clk) begin
      cyc++;
      rst_edge = rst;
      if (rst) begin
         q.delete();
      end else if (start && ready) begin
         q.push_back(model(int'(X), int'(Y), int'(Bin), cyc));
         acc_log.push_back(cyc);
         acc_cnt++;
      end
   end

   // Monitor: compares whenever the DUT presents done.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (rst_edge) begin
         last_d    = '0;
         last_bo   = 1'b0;
         last_ov   = 1'b0;
         prev_done = 1'b0;
      end else begin
         checks++;
         if (ready != !(busy || done) || (busy && done)) begin
            errors++;
            $display("FAIL status ready=%0b busy=%0b done=%0b", ready, busy, done);
         end
         if (done) begin
            checks++;
            if (prev_done) begin
               errors++;
               $display("FAIL done_width done high two cycles at cyc %0d", cyc);
            end
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done at cyc %0d", cyc);
            end else begin
               e = q.pop_front();
               if (Diff !== e.d || Bout !== e.bo || Ovf !== e.ov) begin
                  errors++;
                  $display("FAIL result got D=%h B=%b O=%b want D=%h B=%b O=%b",
                           Diff, Bout, Ovf, e.d, e.bo, e.ov);
               end
               checks++;
               if (cyc - e.cyc != W) begin
                  errors++;
                  $display("FAIL latency got %0d want %0d", cyc - e.cyc, W);
               end
            end
            last_d  = Diff;
            last_bo = Bout;
            last_ov = Ovf;
         end else begin
            checks++;
            if (Diff !== last_d || Bout !== last_bo || Ovf !== last_ov) begin
               errors++;
               $display("FAIL hold got D=%h B=%b O=%b want D=%h B=%b O=%b",
                        Diff, Bout, Ovf, last_d, last_bo, last_ov);
            end
         end
         prev_done = done;
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (!ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!ready) begin
         errors++;
         $display("FAIL idle_timeout ready=%0b want 1", ready);
      end
   endtask

   task automatic run_op(input int x, input int y, input int bi);
      int n;
      int k;
      @(negedge clk);
      X     = W'(x);
      Y     = W'(y);
      Bin   = bi[0];
      start = 1'b1;
      n     = acc_cnt;
      k     = 0;
      while (acc_cnt == n && k < 20) begin
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      checks++;
      if (acc_cnt == n) begin
         errors++;
         $display("FAIL accept_timeout acc=%0d want %0d", acc_cnt, n + 1);
      end
      // Scramble inputs after capture.
      X   = W'($urandom);
      Y   = W'($urandom);
      Bin = 1'($urandom);
      @(negedge clk);
      wait_idle();
   endtask

   initial begin
      int n;
      rst   = 1'b1;
      start = 1'b0;
      X     = '0;
      Y     = '0;
      Bin   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (Diff !== 0 || Bout !== 0 || Ovf !== 0 || ready !== 1 || busy !== 0 || done !== 0) begin
         errors++;
         $display("FAIL reset_state D=%h B=%b O=%b r=%b b=%b d=%b want 0 0 0 1 0 0",
                  Diff, Bout, Ovf, ready, busy, done);
      end

      run_op(13, 5, 0);
      run_op(5, 13, 0);
      run_op(0, 0, 1);
      run_op(15, 15, 1);
      run_op(8, 0, 1);
      run_op(7, 15, 1);

      // Abort mid-op: reset sampled at the second busy edge.
      run_op(13, 5, 0);
      @(negedge clk);
      X     = 4'd2;
      Y     = 4'd9;
      Bin   = 1'b1;
      start = 1'b1;
      n     = acc_cnt;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (acc_cnt != n + 1) begin
         errors++;
         $display("FAIL abort_accept acc=%0d want %0d", acc_cnt, n + 1);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (Diff !== 0 || Bout !== 0 || Ovf !== 0 || ready !== 1 || done !== 0) begin
         errors++;
         $display("FAIL abort_state D=%h B=%b O=%b r=%b d=%b want 0 0 0 1 0",
                  Diff, Bout, Ovf, ready, done);
      end
      repeat (10) @(negedge clk);
      run_op(3, 11, 1);

      // Start held high with inputs changing every cycle.
      acc_log.delete();
      start = 1'b1;
      for (int i = 0; i < 40; i++) begin
         X   = W'($urandom);
         Y   = W'($urandom);
         Bin = 1'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      @(negedge clk);
      wait_idle();
      checks++;
      if (acc_log.size() < 6) begin
         errors++;
         $display("FAIL held_count got %0d want >=6", acc_log.size());
      end
      for (int i = 1; i < acc_log.size(); i++) begin
         checks++;
         if (acc_log[i] - acc_log[i-1] != W + 2) begin
            errors++;
            $display("FAIL held_spacing got %0d want %0d",
                     acc_log[i] - acc_log[i-1], W + 2);
         end
      end

      // Exhaustive sweep.
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int bi = 0; bi < 2; bi++) begin
               run_op(x, y, bi);
            end
         end
      end

      // Random operations.
      for (int i = 0; i < 100; i++) begin
         run_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)));
      end

      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d want 0", q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
